deinterleaver_blk: RTL
======================

// Module: deinterleaver_blk
// PURPOSE
//  Block deinterleaver; the stage directly downstream of the 192-symbol block interleaver.
//  Restores the original symbol order of each frame.
//  Uses a ping-pong RAM: one bank is written while the other is read.
//  Output feeds the decoder front end at one symbol per clock.
// PARAMETERS
//  DW    16  symbol width (bits)
//  ROWS  12  interleaver rows
//  COLS  16  interleaver columns; frame length N = ROWS*COLS = 192
// PORTS
//  clk        in   1   system clock; all logic on rising edge
//  rst        in   1   synchronous, active-high reset
//  x          in   DW  interleaved input symbol
//  in_valid   in   1   x valid this cycle
//  in_sof     in   1   x is the first symbol of a frame (qualified by in_valid)
//  y          out  DW  deinterleaved output symbol
//  out_valid  out  1   y valid this cycle
//  out_sof    out  1   y is the first symbol of a frame
//  frame_err  out  1   one-cycle framing error pulse (only with DEINTL_FRAME_CHK_EN)
// BEHAVIOUR
//  - Reset: y=0, out_valid=0, out_sof=0, frame_err=0; write/read counters=0.
//    Write bank=0; both banks marked empty.
//  - Reset mid-operation: outputs return to reset values on the next edge.
//    All buffered data is discarded.
//  - Write side: symbol k (0..N-1) of a frame is written when in_valid=1.
//    Address: A(k) = (k mod ROWS)*COLS + (k div ROWS).
//    Implemented with row counter r (0..ROWS-1) and column counter c (0..COLS-1); no divider.
//    r wraps to 0 and c increments; at r=ROWS-1 and c=COLS-1 the frame is complete.
//  - Frame complete: the write bank becomes full and the write bank toggles on the same edge.
//    Write index returns to 0.
//  - Read side: starts on the cycle after a bank is marked full.
//    Reads addresses 0..N-1 sequentially, one per cycle, with no stalls.
//    RAM read is registered.
//  - Latency: last input symbol at cycle t gives out_valid=1 and out_sof=1 at t+2.
//    out_valid then stays high for exactly N=192 cycles. out_sof is high only on the first.
//  - A bank returns to empty after its last address is read.
//  - No overflow: the write side takes >= N cycles per frame and the read side takes exactly N.
//    A bank is therefore always empty before it is rewritten.
//  - Back-to-back frames (in_valid held high): output is continuous with no gap.
//    out_sof recurs every 192 cycles.
//  - Gapped input (in_valid=0): write counters hold; out_valid may drop between frames.
//  - Write completion and read completion in the same cycle: both bank flags update; no conflict.
//  - Arithmetic: address width = clog2(2*N); bank bit is the address MSB. Data passes unmodified.
// CONFIGURATION
//  DEINTL_FRAME_CHK_EN defined:
//   - in_sof & in_valid with write index != 0 aborts the partial frame.
//     Index resets so the current symbol is k=0 in the same bank; frame_err pulses 1 cycle.
//   - in_valid at index 0 without in_sof: frame_err pulses; the symbol is accepted as k=0.
//  DEINTL_FRAME_CHK_EN undefined:
//   - in_sof is ignored; frames are delimited purely by count from reset.
//   - frame_err is tied to 0.
// TESTING
//  1 x=k for k=0..191, in_valid=1, in_sof at k=0
//    -> y sequence 0,12,24,...,180,1,13,...; y[16]=1, y[191]=191.
//    out_sof coincides with y=0, 2 cycles after k=191.
//  2 Interleaver->deinterleaver loopback, 5 back-to-back frames of ramp data
//    -> output equals input ramp 0..191 per frame, continuous out_valid, out_sof every 192 cycles.
//  3 in_valid toggling 1/0 every cycle during a frame
//    -> same output as scenario 1; output burst starts 2 cycles after the 192nd accepted symbol.
//  4 Assert rst for 1 cycle at output symbol 100
//    -> next cycle out_valid=0, y=0.
//    A fresh frame afterwards deinterleaves correctly.
//  5 (DEINTL_FRAME_CHK_EN) in_sof at k=50
//    -> frame_err pulse 1 cycle; the frame counted from that symbol outputs correctly, with no output for the aborted data.
//  6 (DEINTL_FRAME_CHK_EN undefined) same stimulus as 5 -> frame_err stays 0; in_sof ignored.

Source files
------------

// File: rtl/deinterleaver_blk.sv
// ============================================================================
// Module   : deinterleaver_blk
// Purpose  : Block deinterleaver for ROWS x COLS frames, ping-pong RAM.
//            Each frame is written column-wise into one bank while the other
//            bank is read out sequentially, restoring the original order.
// Options  : DEINTL_FRAME_CHK_EN - enables in_sof framing check / realign
//            and the frame_err pulse. Undefined: in_sof ignored,
//            frame_err tied low.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module deinterleaver_blk #(
  parameter int DW   = 16,
  parameter int ROWS = 12,
  parameter int COLS = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] x,
  input  logic          in_valid,
  input  logic          in_sof,
  output logic [DW-1:0] y,
  output logic          out_valid,
  output logic          out_sof,
  output logic          frame_err
);

  localparam int N  = ROWS * COLS;
  localparam int AW = $clog2(2 * N);          // bank bit is the MSB
  localparam int OW = AW - 1;                 // offset within a bank
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [RW-1:0] R_LAST  = RW'(ROWS - 1);
  localparam logic [CW-1:0] C_LAST  = CW'(COLS - 1);
  localparam logic [OW-1:0] RD_LAST = OW'(N - 1);

  logic [DW-1:0] mem [0:(2**AW)-1];

  // write side state: symbol index k = c*ROWS + r
  logic [RW-1:0] r;
  logic [CW-1:0] c;
  logic          wr_bank;
  // read side state
  logic          rd_bank;
  logic [OW-1:0] rd_cnt;
  logic [1:0]    full;

  // effective write position after any framing realignment
  logic [RW-1:0] r_eff;
  logic [CW-1:0] c_eff;
  logic          err_now;
  logic          wr_last;
  logic [AW-1:0] wr_addr;
  logic          rd_en;
  logic          rd_last;
  logic [AW-1:0] rd_addr;

`ifdef DEINTL_FRAME_CHK_EN
  logic at_zero;
  logic restart;

  // in_sof mid-frame restarts the current bank at k=0; a frame start
  // without in_sof is flagged but still taken as k=0
  always_comb begin
    at_zero = (r == '0) && (c == '0);
    restart = in_valid && in_sof && !at_zero;
    err_now = in_valid && (in_sof ? !at_zero : at_zero);
    r_eff   = restart ? '0 : r;
    c_eff   = restart ? '0 : c;
  end

  // one-cycle framing error pulse
  always_ff @(posedge clk) begin
    if (rst) frame_err <= 1'b0;
    else     frame_err <= err_now;
  end
`else
  logic unused_sof;
  assign unused_sof = in_sof;

  // frames are delimited purely by symbol count
  always_comb begin
    err_now = 1'b0;
    r_eff   = r;
    c_eff   = c;
  end

  assign frame_err = err_now;
`endif

  // write address A(k) = r*COLS + c in the current write bank; read address
  // walks the read bank sequentially
  always_comb begin
    wr_last = (r_eff == R_LAST) && (c_eff == C_LAST);
    wr_addr = {wr_bank, OW'(OW'(r_eff) * OW'(COLS) + OW'(c_eff))};
    rd_en   = full[rd_bank];
    rd_last = rd_en && (rd_cnt == RD_LAST);
    rd_addr = {rd_bank, rd_cnt};
  end

  // row/column write counters; bank toggles when a frame completes
  always_ff @(posedge clk) begin
    if (rst) begin
      r       <= '0;
      c       <= '0;
      wr_bank <= 1'b0;
    end else if (in_valid) begin
      if (wr_last) begin
        r       <= '0;
        c       <= '0;
        wr_bank <= ~wr_bank;
      end else if (r_eff == R_LAST) begin
        r <= '0;
        c <= c_eff + 1'b1;
      end else begin
        r <= r_eff + 1'b1;
        c <= c_eff;
      end
    end
  end

  // bank full flags: set on write completion, cleared after last read;
  // both may update on the same edge since they address different banks
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 2'b00;
    end else begin
      if (rd_last)             full[rd_bank] <= 1'b0;
      if (in_valid && wr_last) full[wr_bank] <= 1'b1;
    end
  end

  // sequential read counter, runs whenever the read bank is full
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt  <= '0;
      rd_bank <= 1'b0;
    end else if (rd_last) begin
      rd_cnt  <= '0;
      rd_bank <= ~rd_bank;
    end else if (rd_en) begin
      rd_cnt <= rd_cnt + 1'b1;
    end
  end

  // symbol RAM write port (contents need no reset: flags gate reads)
  always_ff @(posedge clk) begin
    if (in_valid) mem[wr_addr] <= x;
  end

  // registered read port and output qualifiers
  always_ff @(posedge clk) begin
    if (rst) begin
      y         <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
    end else begin
      if (rd_en) y <= mem[rd_addr];
      out_valid <= rd_en;
      out_sof   <= rd_en && (rd_cnt == '0);
    end
  end

endmodule

`default_nettype wire
